// File: rtl/spi_pkg.sv
// Shared SPI constants: clock mode encoding and default word parameters.
package spi_pkg;

    // {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE_0        = 2'b00;
    localparam int         DEFAULT_DATAWIDTH = 8;
    localparam logic [7:0] TX_IDLE_DEFAULT   = 8'h00;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous pin, plus a history flop that
// turns level changes into single-cycle rise/fall strobes.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    // Reset to the idle pin level so leaving reset never fakes an edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_hist <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_hist;
    assign o_fall  = ~r_sync & r_hist;

endmodule

// File: rtl/spi_peripheral.sv
// Mode-0 SPI peripheral, oversampled by i_clk: MSB-first RX/TX shift registers
// with a single-entry TX buffer refilled at CS fall and at every word boundary.
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int                   DATAWIDTH = DEFAULT_DATAWIDTH,
    parameter logic [DATAWIDTH-1:0] TX_IDLE   = DATAWIDTH'(TX_IDLE_DEFAULT)
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_spi_clk,
    input  logic                 i_spi_cs_n,
    input  logic                 i_spi_mosi,
    output logic                 o_spi_miso,
    output logic                 o_spi_miso_oe,
    output logic [DATAWIDTH-1:0] o_rx_data,
    output logic                 o_rx_valid,
    input  logic [DATAWIDTH-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    output logic                 o_tx_underrun
);

    localparam int          CNT_W    = $clog2(DATAWIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATAWIDTH - 1);
    localparam logic        CPOL     = SPI_MODE_0[1];
    localparam logic        CPHA     = SPI_MODE_0[0];

    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_cs_n_level, w_cs_fall, w_cs_rise;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_sample_edge, w_shift_edge;
    logic w_tx_write, w_tx_load;
    logic w_unused_sync;

    logic [CNT_W-1:0]     r_bit_cnt;
    logic [DATAWIDTH-1:0] r_rx_shift;
    logic [DATAWIDTH-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic [DATAWIDTH-1:0] r_tx_shift;
    logic [DATAWIDTH-1:0] r_tx_buf;
    logic                 r_tx_full;
    logic                 r_tx_underrun;
    logic                 r_reload;
    logic                 r_active;

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_async(i_spi_clk),
        .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_async(i_spi_cs_n),
        .o_level(w_cs_n_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_async(i_spi_mosi),
        .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused_sync = ^{w_sclk_level, w_cs_n_level, w_mosi_rise, w_mosi_fall};

    // Mode 0: sample on the leading (rising) edge, shift on the trailing one.
    assign w_sample_edge = (CPOL ^ CPHA) ? w_sclk_fall : w_sclk_rise;
    assign w_shift_edge  = (CPOL ^ CPHA) ? w_sclk_rise : w_sclk_fall;

    assign w_tx_write = i_tx_valid & ~r_tx_full;
    assign w_tx_load  = w_cs_fall | (r_active & w_shift_edge & r_reload);

    // TX side: buffer, shift register and underrun flag.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tx_buf      <= '0;
            r_tx_full     <= 1'b0;
            r_tx_shift    <= '0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_tx_underrun <= 1'b0;
            // A write landing with a load keeps the new word for the next load.
            if (w_tx_write) begin
                r_tx_buf  <= i_tx_data;
                r_tx_full <= 1'b1;
            end else if (w_tx_load) begin
                r_tx_full <= 1'b0;
            end
            if (w_tx_load) begin
                r_tx_shift    <= r_tx_full ? r_tx_buf : TX_IDLE;
                r_tx_underrun <= ~r_tx_full;
            end else if (r_active && w_shift_edge) begin
                r_tx_shift <= {r_tx_shift[DATAWIDTH-2:0], 1'b0};
            end
        end
    end

    // RX side and frame control.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_active   <= 1'b0;
            r_bit_cnt  <= '0;
            r_reload   <= 1'b0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_cs_fall) begin
                r_active  <= 1'b1;
                r_bit_cnt <= '0;
                r_reload  <= 1'b0;
            end else if (w_cs_rise) begin
                r_active   <= 1'b0;
                r_bit_cnt  <= '0;
                r_reload   <= 1'b0;
                r_rx_shift <= '0;
            end else if (r_active) begin
                if (w_sample_edge) begin
                    r_rx_shift <= {r_rx_shift[DATAWIDTH-2:0], w_mosi};
                    if (r_bit_cnt == LAST_BIT) begin
                        r_bit_cnt  <= '0;
                        r_rx_data  <= {r_rx_shift[DATAWIDTH-2:0], w_mosi};
                        r_rx_valid <= 1'b1;
                        r_reload   <= 1'b1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end else if (w_shift_edge) begin
                    r_reload <= 1'b0;
                end
            end
        end
    end

    assign o_spi_miso    = r_tx_shift[DATAWIDTH-1];
    assign o_spi_miso_oe = r_active;
    assign o_rx_data     = r_rx_data;
    assign o_rx_valid    = r_rx_valid;
    assign o_tx_ready    = ~r_tx_full;
    assign o_tx_underrun = r_tx_underrun;

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: directed frames plus randomized frames checked
// against a queue-based model of the TX buffer and the received words.
`timescale 1ns/1ps
module tb_spi_peripheral;

    localparam int W    = 8;
    localparam int HALF = 6;   // i_clk cycles per SCLK phase

    logic         i_clk = 1'b0;
    logic         i_reset_n;
    logic         i_spi_clk;
    logic         i_spi_cs_n;
    logic         i_spi_mosi;
    logic         o_spi_miso;
    logic         o_spi_miso_oe;
    logic [W-1:0] o_rx_data;
    logic         o_rx_valid;
    logic [W-1:0] i_tx_data;
    logic         i_tx_valid;
    logic         o_tx_ready;
    logic         o_tx_underrun;

    always #5 i_clk = ~i_clk;

    spi_peripheral dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_spi_clk(i_spi_clk), .i_spi_cs_n(i_spi_cs_n), .i_spi_mosi(i_spi_mosi),
        .o_spi_miso(o_spi_miso), .o_spi_miso_oe(o_spi_miso_oe),
        .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid),
        .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid),
        .o_tx_ready(o_tx_ready), .o_tx_underrun(o_tx_underrun)
    );

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic [W-1:0] model_buf[$];   // contents of the TX buffer (0 or 1 entries)
    logic [W-1:0] cur_tx;         // word the model says MISO is shifting
    int           underrun_seen = 0;
    int           underrun_exp  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    always @(negedge i_clk) begin
        if (i_reset_n) begin
            if (o_rx_valid)    got_q.push_back(o_rx_data);
            if (o_tx_underrun) underrun_seen++;
        end
    end

    task automatic model_load();
        if (model_buf.size() > 0) cur_tx = model_buf.pop_front();
        else begin
            cur_tx = 8'h00;
            underrun_exp++;
        end
    endtask

    task automatic tx_write(input logic [W-1:0] d);
        check("tx_ready_before_write", 32'(o_tx_ready), 32'd1);
        i_tx_valid = 1'b1;
        i_tx_data  = d;
        cycles(1);
        i_tx_valid = 1'b0;
        check("tx_ready_after_write", 32'(o_tx_ready), 32'd0);
        model_buf.push_back(d);
    endtask

    task automatic spi_bit(input logic b, output logic m);
        i_spi_mosi = b;
        cycles(HALF);
        m = o_spi_miso;
        i_spi_clk = 1'b1;
        cycles(HALF);
        i_spi_clk = 1'b0;
    endtask

    task automatic verify_rx();
        check("rx_count", 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            check("rx_data", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        exp_q.delete();
        got_q.delete();
    endtask

    // One CS frame of nbits; optionally writes the TX buffer mid-frame while SCLK is high.
    task automatic run_frame(input int nbits, input logic [31:0] mosi,
                             input bit do_wr, input int wr_bit, input logic [W-1:0] wr_data);
        logic [W-1:0] got_w;
        int r;
        got_w = '0;
        i_spi_cs_n = 1'b0;
        model_load();
        cycles(HALF);
        check("miso_oe_active", 32'(o_spi_miso_oe), 32'd1);
        for (int i = 0; i < nbits; i++) begin
            i_spi_mosi = mosi[31-i];
            cycles(HALF);
            got_w = {got_w[W-2:0], o_spi_miso};
            i_spi_clk = 1'b1;
            if (do_wr && i == wr_bit && model_buf.size() == 0) begin
                cycles(1);
                tx_write(wr_data);
                cycles(HALF - 2);
            end else begin
                cycles(HALF);
            end
            i_spi_clk = 1'b0;
            if (i % 8 == 7) begin
                check("miso_word", 32'(got_w), 32'(cur_tx));
                exp_q.push_back(mosi[31-(i-7) -: 8]);
                model_load();
            end
        end
        cycles(HALF);
        r = nbits % 8;
        if (r != 0)
            check("miso_partial", 32'(got_w) & ((32'd1 << r) - 32'd1), 32'(cur_tx) >> (8 - r));
        i_spi_cs_n = 1'b1;
        cycles(HALF);
        check("miso_oe_idle", 32'(o_spi_miso_oe), 32'd0);
        verify_rx();
        check("underrun_count", 32'(underrun_seen), 32'(underrun_exp));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_data"},  32'(o_rx_data), 32'd0);
        check({tag, "_rx_valid"}, 32'(o_rx_valid), 32'd0);
        check({tag, "_tx_ready"}, 32'(o_tx_ready), 32'd1);
        check({tag, "_underrun"}, 32'(o_tx_underrun), 32'd0);
        check({tag, "_miso"},     32'(o_spi_miso), 32'd0);
        check({tag, "_miso_oe"},  32'(o_spi_miso_oe), 32'd0);
    endtask

    initial begin
        int           nb;
        logic [31:0]  mv;
        logic         m;
        logic [3:0]   prefix;

        i_reset_n  = 1'b0;
        i_spi_clk  = 1'b0;
        i_spi_cs_n = 1'b1;
        i_spi_mosi = 1'b0;
        i_tx_valid = 1'b0;
        i_tx_data  = '0;
        cycles(3);
        check_reset_outputs("reset");
        i_reset_n = 1'b1;
        cycles(3);

        // Loaded word shifted out while a known byte is received.
        tx_write(8'hA5);
        run_frame(8, 32'h3C00_0000, 1'b0, 0, 8'h00);

        // Back-to-back words in one frame; second word written during the first.
        tx_write(8'h11);
        run_frame(16, 32'h5AC3_0000, 1'b1, 2, 8'h22);

        // Empty buffer at CS fall: idle word and underrun.
        run_frame(8, 32'h8100_0000, 1'b0, 0, 8'h00);

        // Aborted frame after 5 bits, then a clean F0 frame.
        run_frame(5, 32'hFFFF_FFFF, 1'b0, 0, 8'h00);
        run_frame(8, 32'hF000_0000, 1'b0, 0, 8'h00);
        check("rx_data_after_abort", 32'(o_rx_data), 32'hF0);

        // SCLK activity with CS high must be ignored.
        for (int i = 0; i < 6; i++) begin
            i_spi_mosi = 1'b1;
            i_spi_clk  = 1'b1;
            cycles(HALF);
            i_spi_clk  = 1'b0;
            cycles(HALF);
        end
        check("idle_sclk_miso_oe", 32'(o_spi_miso_oe), 32'd0);
        verify_rx();
        run_frame(8, 32'h6900_0000, 1'b0, 0, 8'h00);

        // Reset in the middle of a frame, then a fresh frame.
        tx_write(8'h5A);
        i_spi_cs_n = 1'b0;
        model_load();
        cycles(HALF);
        prefix = '0;
        for (int i = 0; i < 4; i++) begin
            spi_bit(1'b1, m);
            prefix = {prefix[2:0], m};
        end
        check("pre_reset_miso_bits", 32'(prefix), 32'h5);
        i_reset_n = 1'b0;
        cycles(1);
        check_reset_outputs("midreset");
        i_spi_cs_n = 1'b1;
        i_spi_mosi = 1'b0;
        cycles(2);
        i_reset_n = 1'b1;
        model_buf.delete();
        exp_q.delete();
        got_q.delete();
        underrun_seen = 0;
        underrun_exp  = 0;
        cycles(4);
        tx_write(8'hC3);
        run_frame(8, 32'h9600_0000, 1'b0, 0, 8'h00);
        check("rx_data_after_reset", 32'(o_rx_data), 32'h96);

        // Randomized frames: lengths, partial aborts, preloads and mid-frame writes.
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 3) == 0) nb = $urandom_range(1, 23);
            else                           nb = 8 * $urandom_range(1, 3);
            mv = $urandom;
            if (model_buf.size() == 0 && $urandom_range(0, 1) == 1) tx_write(8'($urandom));
            run_frame(nb, mv, 1'($urandom_range(0, 1)), $urandom_range(0, nb - 1), 8'($urandom));
            cycles($urandom_range(2, 10));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
